// File: rtl/usb_line_pkg.sv
// Shared line-state and transmit-FSM types for the USB-style line.
// Also holds the SYNC pattern and the NRZI step used by the tx path.
package usb_line_pkg;

  typedef enum logic [1:0] {
    LS_J,
    LS_K,
    LS_SE0
  } line_state_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SYNC,
    ST_DATA,
    ST_STUFF,
    ST_EOP_SE0,
    ST_EOP_J
  } tx_state_t;

  localparam logic [7:0] SYNC_PATTERN = 8'h80;
  localparam int STUFF_LIMIT_DEF = 6;

  // A 0 toggles the line level, a 1 holds it.
  function automatic line_state_t nrzi(
    input line_state_t lvl,
    input logic        b
  );
    if (b) return lvl;
    return (lvl == LS_J) ? LS_K : LS_J;
  endfunction

endpackage

// File: rtl/usb_sync_tx_if.sv
// Byte-stream handshake between the packet assembler and the tx front-end.
// The source drives valid/data/last; the front-end returns ready.
interface usb_sync_tx_if;

  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_last;
  logic       tx_ready;

  modport master (
    output tx_valid,
    output tx_data,
    output tx_last,
    input  tx_ready
  );

  modport slave (
    input  tx_valid,
    input  tx_data,
    input  tx_last,
    output tx_ready
  );

endinterface

// File: rtl/usb_bit_tick.sv
// Line bit-period counter; tick marks the last clock of each period.
// tick_nx_o looks one clock ahead so callers can register tick-aligned outputs.
module usb_bit_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o,
  output logic tick_nx_o
);

  localparam int CW =
    (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tick_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i) begin
      cnt_d = tick_o ? '0 : cnt_q + CW'(1);
    end
  end

  assign tick_nx_o = (cnt_d == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/usb_sync_tx.sv
// USB-style transmit front-end: SYNC, NRZI + bit-stuffed data, EOP.
// Line outputs are registered and only move on bit-period boundaries.
module usb_sync_tx
  import usb_line_pkg::*;
#(
  parameter int CLKS_PER_BIT = 1,
  parameter int STUFF_LIMIT  = STUFF_LIMIT_DEF,
  parameter int EOP_SE0_BITS = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  usb_sync_tx_if.slave  bus,
  output logic          tx_en,
  output logic          k,
  output logic          j,
  output logic          se0,
  output logic          tx_done,
  output logic          tx_err
);

  localparam logic [7:0] LIM      = 8'(STUFF_LIMIT);
  localparam logic [7:0] SE0_LAST = 8'(EOP_SE0_BITS - 1);

  tx_state_t   state_q, state_d;
  line_state_t lvl_q, lvl_d;
  line_state_t ls_q, ls_d;
  logic [7:0]  sh_q, sh_d;
  logic        last_q, last_d;
  logic [7:0]  idx_q, idx_d;
  logic [7:0]  ones_q, ones_d;
  logic        en_q, en_d;
  logic        j_q, k_q, se0_q;
  logic        rdy_q, rdy_d;
  logic        done_q, done_d;
  logic        err_q, err_d;

  logic        tick;
  logic        tick_nx;
  logic        clr;
  logic        emit;
  logic        ebit;
  logic        hand_nx;

  usb_bit_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_tick (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (state_q != ST_IDLE),
    .clr_i    (clr),
    .tick_o   (tick),
    .tick_nx_o(tick_nx)
  );

  always_comb begin
    state_d = state_q;
    lvl_d   = lvl_q;
    ls_d    = ls_q;
    sh_d    = sh_q;
    last_d  = last_q;
    idx_d   = idx_q;
    ones_d  = ones_q;
    en_d    = en_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    clr     = 1'b0;
    emit    = 1'b0;
    ebit    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        lvl_d = LS_J;
        ls_d  = LS_J;
        en_d  = 1'b0;
        if (rdy_q && bus.tx_valid) begin
          state_d = ST_SYNC;
          sh_d    = bus.tx_data;
          last_d  = bus.tx_last;
          idx_d   = '0;
          ones_d  = '0;
          en_d    = 1'b1;
          clr     = 1'b1;
          emit    = 1'b1;
          ebit    = SYNC_PATTERN[0];
        end
      end
      ST_SYNC: begin
        if (tick) begin
          emit = 1'b1;
          if (idx_q == 8'd7) begin
            state_d = ST_DATA;
            idx_d   = '0;
            ebit    = sh_q[0];
          end else begin
            idx_d = idx_q + 8'd1;
            ebit  = SYNC_PATTERN[idx_d[2:0]];
          end
        end
      end
      ST_DATA, ST_STUFF: begin
        if (tick) begin
          // A due stuff bit always goes out before handoff or EOP.
          if (ones_q == LIM) begin
            state_d = ST_STUFF;
            emit    = 1'b1;
          end else if (idx_q != 8'd7) begin
            state_d = ST_DATA;
            idx_d   = idx_q + 8'd1;
            emit    = 1'b1;
            ebit    = sh_q[idx_d[2:0]];
          end else if (!last_q && bus.tx_valid) begin
            state_d = ST_DATA;
            sh_d    = bus.tx_data;
            last_d  = bus.tx_last;
            idx_d   = '0;
            emit    = 1'b1;
            ebit    = bus.tx_data[0];
          end else begin
            state_d = ST_EOP_SE0;
            ls_d    = LS_SE0;
            idx_d   = '0;
            err_d   = !last_q;
          end
        end
      end
      ST_EOP_SE0: begin
        if (tick) begin
          if (idx_q == SE0_LAST) begin
            state_d = ST_EOP_J;
            ls_d    = LS_J;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end
      end
      ST_EOP_J: begin
        if (tick) begin
          state_d = ST_IDLE;
          en_d    = 1'b0;
          ls_d    = LS_J;
          lvl_d   = LS_J;
          idx_d   = '0;
          ones_d  = '0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (emit) begin
      lvl_d  = nrzi(lvl_d, ebit);
      ls_d   = lvl_d;
      ones_d = ebit ? ones_q + 8'd1 : 8'd0;
    end
  end

  // Ready must line up with the tick that closes bit 7 of a non-last byte.
  assign hand_nx = ((state_d == ST_DATA) || (state_d == ST_STUFF))
                && (idx_d == 8'd7)
                && (ones_d != LIM)
                && !last_d
                && tick_nx;

  assign rdy_d = (state_d == ST_IDLE) || hand_nx;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      lvl_q   <= LS_J;
      ls_q    <= LS_J;
      sh_q    <= '0;
      last_q  <= 1'b0;
      idx_q   <= '0;
      ones_q  <= '0;
      en_q    <= 1'b0;
      j_q     <= 1'b1;
      k_q     <= 1'b0;
      se0_q   <= 1'b0;
      rdy_q   <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lvl_q   <= lvl_d;
      ls_q    <= ls_d;
      sh_q    <= sh_d;
      last_q  <= last_d;
      idx_q   <= idx_d;
      ones_q  <= ones_d;
      en_q    <= en_d;
      j_q     <= (ls_d == LS_J);
      k_q     <= (ls_d == LS_K);
      se0_q   <= (ls_d == LS_SE0);
      rdy_q   <= rdy_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign bus.tx_ready = rdy_q;
  assign tx_en        = en_q;
  assign j            = j_q;
  assign k            = k_q;
  assign se0          = se0_q;
  assign tx_done      = done_q;
  assign tx_err       = err_q;

endmodule

// File: tb/tb_usb_sync_tx.sv
// Directed bench for usb_sync_tx: vector table plus reset/timing corners.
// Line symbols are logged as K, J or 0 (SE0) while tx_en is high.
module tb_usb_sync_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tv, tl, sel;
  logic [7:0] td;

  usb_sync_tx_if bus1();
  usb_sync_tx_if bus4();

  assign bus1.tx_valid = tv & ~sel;
  assign bus1.tx_data  = td;
  assign bus1.tx_last  = tl;
  assign bus4.tx_valid = tv & sel;
  assign bus4.tx_data  = td;
  assign bus4.tx_last  = tl;

  logic en1, k1, j1, s1, d1, e1;
  logic en4, k4, j4, s4, d4, e4;

  usb_sync_tx #(.CLKS_PER_BIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(bus1),
    .tx_en(en1), .k(k1), .j(j1), .se0(s1),
    .tx_done(d1), .tx_err(e1)
  );

  usb_sync_tx #(.CLKS_PER_BIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .bus(bus4),
    .tx_en(en4), .k(k4), .j(j4), .se0(s4),
    .tx_done(d4), .tx_err(e4)
  );

  logic o_en, o_k, o_j, o_s, o_d, o_e, o_rdy;
  assign o_en  = sel ? en4 : en1;
  assign o_k   = sel ? k4  : k1;
  assign o_j   = sel ? j4  : j1;
  assign o_s   = sel ? s4  : s1;
  assign o_d   = sel ? d4  : d1;
  assign o_e   = sel ? e4  : e1;
  assign o_rdy = sel ? bus4.tx_ready : bus1.tx_ready;

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct packed {
    logic [7:0] b0;
    logic       last0;
    logic       has_b1;
    logic [7:0] b1;
    int         rdy_at;
    int         err_at;
  } vec_t;

  vec_t  tab[5];
  string exp_tab[5];

  task automatic chk(input string nm, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic chk_s(input string nm, input string got,
                       input string exp);
    n_chk++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %s expected %s", nm, got, exp);
    end
  endtask

  task automatic wait_ready(input string nm);
    int w;
    w = 0;
    while (!o_rdy && w < 50) begin
      @(negedge clk);
      w++;
    end
    chk({nm, " idle_ready"}, int'(o_rdy), 1);
  endtask

  task automatic run_vec(input int i, input int rep);
    vec_t  v;
    string e, got, nm;
    int    n, rc, rf, ec, ef, oh;
    logic  acc;
    v  = tab[i];
    nm = $sformatf("v%0d_x%0d", i, rep);
    e  = "";
    for (int c = 0; c < exp_tab[i].len(); c++) begin
      for (int r = 0; r < rep; r++) begin
        e = {e, exp_tab[i].substr(c, c)};
      end
    end
    wait_ready(nm);
    td = v.b0;
    tl = v.last0;
    tv = 1'b1;
    @(posedge clk);
    #1;
    if (v.has_b1) begin
      td = v.b1;
      tl = 1'b1;
    end else begin
      tv = 1'b0;
      td = 8'h00;
      tl = 1'b0;
    end
    @(negedge clk);
    got = "";
    n = 0; rc = 0; rf = -1; ec = 0; ef = -1; oh = 0;
    while (o_en && n < 60 * rep) begin
      if (o_s)      got = {got, "0"};
      else if (o_k) got = {got, "K"};
      else if (o_j) got = {got, "J"};
      else          got = {got, "?"};
      if (int'(o_s) + int'(o_k) + int'(o_j) != 1) oh++;
      if (o_rdy) begin
        rc++;
        if (rf < 0) rf = n;
      end
      if (o_e) begin
        ec++;
        if (ef < 0) ef = n;
      end
      acc = o_rdy && tv;
      @(posedge clk);
      #1;
      if (acc) tv = 1'b0;
      @(negedge clk);
      n++;
    end
    tv = 1'b0;
    chk_s({nm, " line"}, got, e);
    chk({nm, " onehot_bad"}, oh, 0);
    chk({nm, " ready_cnt"}, rc, (v.rdy_at >= 0) ? 1 : 0);
    chk({nm, " ready_pos"}, rf, (v.rdy_at >= 0) ? v.rdy_at * rep + rep - 1 : -1);
    chk({nm, " err_cnt"}, ec, (v.err_at >= 0) ? 1 : 0);
    chk({nm, " err_pos"}, ef, (v.err_at >= 0) ? v.err_at * rep : -1);
    chk({nm, " done_pulse"}, int'(o_d), 1);
    chk({nm, " idle_j"}, int'(o_j), 1);
    @(negedge clk);
    chk({nm, " done_clear"}, int'(o_d), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    tab[0] = '{8'h00, 1'b1, 1'b0, 8'h00, -1, -1};
    tab[1] = '{8'hFF, 1'b1, 1'b0, 8'h00, -1, -1};
    tab[2] = '{8'hA5, 1'b0, 1'b1, 8'h3C, 15, -1};
    tab[3] = '{8'h11, 1'b0, 1'b0, 8'h00, 15, 16};
    tab[4] = '{8'hFC, 1'b1, 1'b0, 8'h00, -1, -1};
    exp_tab[0] = "KJKJKJKKJKJKJKJK00J";
    exp_tab[1] = "KJKJKJKKKKKKKJJJJ00J";
    exp_tab[2] = "KJKJKJKKKJJKJJKKJKKKKKJK00J";
    exp_tab[3] = "KJKJKJKKKJKJJKJK00J";
    exp_tab[4] = "KJKJKJKKJKKKKKKKJ00J";

    tv = 1'b0; td = 8'h00; tl = 1'b0; sel = 1'b0;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst tx_en", int'(o_en), 0);
    chk("rst j", int'(o_j), 1);
    chk("rst k", int'(o_k), 0);
    chk("rst se0", int'(o_s), 0);
    chk("rst ready", int'(o_rdy), 0);
    chk("rst done", int'(o_d), 0);
    chk("rst err", int'(o_e), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      run_vec(i, 1);
    end

    sel = 1'b1;
    run_vec(0, 4);
    sel = 1'b0;
    @(negedge clk);

    wait_ready("midrst");
    td = 8'hFF; tl = 1'b1; tv = 1'b1;
    @(posedge clk);
    #1;
    tv = 1'b0;
    repeat (12) @(negedge clk);
    chk("midrst busy", int'(o_en), 1);
    #2;
    rst_n = 1'b0;
    #1;
    chk("midrst tx_en", int'(o_en), 0);
    chk("midrst j", int'(o_j), 1);
    chk("midrst k", int'(o_k), 0);
    chk("midrst se0", int'(o_s), 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(0, 1);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
